// File: rtl/pipeline_sink_checker.sv
`timescale 1ns/1ps
// Two-lane downstream sink: per-lane FIFO with occupancy backpressure, rate-limited drain and a stride-2 sequence checker.
// Build option: define SINK_RANDOM_DRAIN_EN to drain on a 16-bit LFSR tick (~25%) instead of every DRAIN_PERIOD cycles.
module pipeline_sink_checker #(
  parameter int DATA_W       = 32,
  parameter int FIFO_DEPTH   = 8,
  parameter int SKID         = 3,
  parameter int DRAIN_PERIOD = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              out_valid_1,
  input  logic [DATA_W-1:0] out_data_1,
  input  logic              out_valid_2,
  input  logic [DATA_W-1:0] out_data_2,
  input  logic              flush_1,
  input  logic              flush_2,
  output logic              stall_1,
  output logic              stall_2,
  output logic [31:0]       match_count,
  output logic [15:0]       err_count,
  output logic              overflow,
  output logic [1:0]        err_lane
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DC_W  = (DRAIN_PERIOD > 1) ? $clog2(DRAIN_PERIOD) : 1;
  localparam logic [CNT_W-1:0] FULL   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] THRESH = CNT_W'(FIFO_DEPTH - SKID);

  typedef enum logic {SYNC, TRACK} chk_state_e;

  logic [1:0]        lane_valid;
  logic [1:0]        lane_flush;
  logic [DATA_W-1:0] lane_data [2];
  logic [1:0]        stall_vec, hit_vec, miss_vec, ovf_vec;
  logic              tick;

  assign lane_valid   = {out_valid_2, out_valid_1};
  assign lane_flush   = {flush_2, flush_1};
  assign lane_data[0] = out_data_1;
  assign lane_data[1] = out_data_2;

`ifdef SINK_RANDOM_DRAIN_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign tick = (lfsr_q[1:0] == 2'b00);
`else
  logic [DC_W-1:0] drain_cnt_q;

  assign tick = (drain_cnt_q == DC_W'(DRAIN_PERIOD - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     drain_cnt_q <= '0;
    else if (tick) drain_cnt_q <= '0;
    else           drain_cnt_q <= drain_cnt_q + DC_W'(1);
  end
`endif

  for (genvar n = 0; n < 2; n++) begin : g_lane
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    chk_state_e        chk_q, chk_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [DATA_W-1:0] head;
    logic              push, pop;

    // A flush cancels both the arriving item and any pop scheduled this cycle.
    assign head         = mem_q[rd_ptr_q];
    assign pop          = tick && (count_q != '0) && !lane_flush[n];
    assign push         = lane_valid[n] && !lane_flush[n] && ((count_q != FULL) || pop);
    assign ovf_vec[n]   = lane_valid[n] && !lane_flush[n] && (count_q == FULL) && !pop;
    assign hit_vec[n]   = pop && ((chk_q == SYNC) || (head == exp_q));
    assign miss_vec[n]  = pop && (chk_q == TRACK) && (head != exp_q);
    assign stall_vec[n] = (count_q >= THRESH);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      chk_d    = chk_q;
      exp_d    = exp_q;
      if (lane_flush[n]) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
        chk_d    = SYNC;
      end else begin
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          chk_d    = TRACK;
          exp_d    = head + DATA_W'(2);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
    end

    // NOTE: storage has no reset; count/pointers define validity, so stale contents are never read.
    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= lane_data[n];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        chk_q    <= SYNC;
        exp_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        chk_q    <= chk_d;
        exp_q    <= exp_d;
      end
    end
  end

  logic [31:0] match_count_q, match_count_d;
  logic [15:0] err_count_q, err_count_d;
  logic [16:0] err_sum;
  logic [1:0]  err_lane_q, err_lane_d;
  logic        overflow_q;

  always_comb begin
    match_count_d = match_count_q + 32'(hit_vec[0]) + 32'(hit_vec[1]);
    err_sum       = {1'b0, err_count_q} + 17'(miss_vec[0]) + 17'(miss_vec[1]);
    err_count_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    err_lane_d    = (|miss_vec) ? miss_vec : err_lane_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_count_q <= '0;
      err_count_q   <= '0;
      err_lane_q    <= '0;
      overflow_q    <= 1'b0;
    end else begin
      match_count_q <= match_count_d;
      err_count_q   <= err_count_d;
      err_lane_q    <= err_lane_d;
      overflow_q    <= overflow_q | (|ovf_vec);
    end
  end

  assign stall_1     = stall_vec[0];
  assign stall_2     = stall_vec[1];
  assign match_count = match_count_q;
  assign err_count   = err_count_q;
  assign err_lane    = err_lane_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_pipeline_sink_checker.sv
`timescale 1ns/1ps
// Self-checking bench for pipeline_sink_checker (default periodic-drain build, default parameters).
module tb_pipeline_sink_checker;

  localparam int DEPTH  = 8;
  localparam int SKID   = 3;
  localparam int PERIOD = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        out_valid_1 = 1'b0, out_valid_2 = 1'b0;
  logic [31:0] out_data_1 = '0, out_data_2 = '0;
  logic        flush_1 = 1'b0, flush_2 = 1'b0;
  logic        stall_1, stall_2, overflow;
  logic [31:0] match_count;
  logic [15:0] err_count;
  logic [1:0]  err_lane;

  always #5 clk = ~clk;

  pipeline_sink_checker dut (
    .clk         (clk),
    .reset       (reset),
    .out_valid_1 (out_valid_1),
    .out_data_1  (out_data_1),
    .out_valid_2 (out_valid_2),
    .out_data_2  (out_data_2),
    .flush_1     (flush_1),
    .flush_2     (flush_2),
    .stall_1     (stall_1),
    .stall_2     (stall_2),
    .match_count (match_count),
    .err_count   (err_count),
    .overflow    (overflow),
    .err_lane    (err_lane)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: accepted items queue per lane, popped on modelled drain ticks.
  logic [31:0] sb_q0 [$];
  logic [31:0] sb_q1 [$];
  int          m_drain;
  bit          m_track [2];
  logic [31:0] m_exp [2];
  logic [31:0] m_match;
  int          m_err;
  logic [1:0]  m_err_lane;
  bit          m_ovf;
  bit          saw_stall1, saw_stall2;

  function automatic int sb_size(input int n);
    return (n == 0) ? sb_q0.size() : sb_q1.size();
  endfunction

  task automatic sb_push(input int n, input logic [31:0] v);
    if (n == 0) sb_q0.push_back(v); else sb_q1.push_back(v);
  endtask

  task automatic sb_pop(input int n, output logic [31:0] v);
    if (n == 0) v = sb_q0.pop_front(); else v = sb_q1.pop_front();
  endtask

  task automatic sb_clear(input int n);
    if (n == 0) sb_q0.delete(); else sb_q1.delete();
  endtask

  task automatic model_reset();
    sb_clear(0);
    sb_clear(1);
    m_drain    = 0;
    m_track    = '{0, 0};
    m_exp      = '{32'd0, 32'd0};
    m_match    = '0;
    m_err      = 0;
    m_err_lane = '0;
    m_ovf      = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit          tick;
    bit          vld [2];
    bit          fl [2];
    logic [31:0] dat [2];
    logic [31:0] v;
    logic [1:0]  errs;
    int          hits;
    tick = (m_drain == PERIOD - 1);
    vld  = '{out_valid_1, out_valid_2};
    fl   = '{flush_1, flush_2};
    dat  = '{out_data_1, out_data_2};
    errs = '0;
    hits = 0;
    for (int n = 0; n < 2; n++) begin
      if (fl[n]) begin
        sb_clear(n);
        m_track[n] = 0;
      end else begin
        if (tick && sb_size(n) > 0) begin
          sb_pop(n, v);
          if (!m_track[n] || v == m_exp[n]) hits++;
          else errs[n] = 1'b1;
          m_exp[n]   = v + 32'd2;
          m_track[n] = 1;
        end
        if (vld[n]) begin
          if (sb_size(n) < DEPTH) sb_push(n, dat[n]);
          else m_ovf = 1;
        end
      end
    end
    m_match = m_match + 32'(hits);
    m_err   = m_err + $countones(errs);
    if (m_err > 65535) m_err = 65535;
    if (errs != 2'b00) m_err_lane = errs;
    m_drain = tick ? 0 : m_drain + 1;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    if (stall_1) saw_stall1 = 1;
    if (stall_2) saw_stall2 = 1;
    check("stall_1",     32'(stall_1),     32'(sb_size(0) >= DEPTH - SKID));
    check("stall_2",     32'(stall_2),     32'(sb_size(1) >= DEPTH - SKID));
    check("match_count", match_count,      m_match);
    check("err_count",   32'(err_count),   32'(m_err));
    check("err_lane",    32'(err_lane),    32'(m_err_lane));
    check("overflow",    32'(overflow),    32'(m_ovf));
  endtask

  task automatic drive(input bit v1, input logic [31:0] d1, input bit v2, input logic [31:0] d2);
    out_valid_1 = v1;
    out_data_1  = d1;
    out_valid_2 = v2;
    out_data_2  = d2;
    step();
    out_valid_1 = 1'b0;
    out_valid_2 = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(0, '0, 0, '0);
  endtask

  // Called 1ns after a rising edge; reset is released before the next one.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #2;
    check({tag, "_stall_1"},     32'(stall_1),   32'd0);
    check({tag, "_stall_2"},     32'(stall_2),   32'd0);
    check({tag, "_match_count"}, match_count,    32'd0);
    check({tag, "_err_count"},   32'(err_count), 32'd0);
    check({tag, "_overflow"},    32'(overflow),  32'd0);
    check({tag, "_err_lane"},    32'(err_lane),  32'd0);
    model_reset();
    saw_stall1 = 0;
    saw_stall2 = 0;
    #3;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int seq;
    model_reset();
    @(posedge clk);
    #1;

    // Clean stream on both lanes, one item per lane every two cycles.
    do_reset("rst0");
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'(2 * i), 1, 32'(2 * i + 1));
      idle(1);
    end
    idle(10);
    check("clean_match",    match_count,      32'd40);
    check("clean_err",      32'(err_count),   32'd0);
    check("clean_overflow", 32'(overflow),    32'd0);
    check("clean_no_stall", 32'(saw_stall1 | saw_stall2), 32'd0);

    // Backpressure: lane 1 offers every cycle and honours stall_1.
    do_reset("rst_bp");
    sent = 0;
    for (int i = 0; i < 40; i++) begin
      if (!stall_1) begin
        drive(1, 32'(2 * sent), 0, '0);
        sent++;
      end else begin
        drive(0, '0, 0, '0);
      end
    end
    idle(20);
    check("bp_saw_stall", 32'(saw_stall1),  32'd1);
    check("bp_overflow",  32'(overflow),    32'd0);
    check("bp_match",     match_count,      32'(sent));
    check("bp_err",       32'(err_count),   32'd0);

    // Gap on lane 2: 1,3,7,9.
    do_reset("rst_gap");
    drive(0, '0, 1, 32'd1); idle(1);
    drive(0, '0, 1, 32'd3); idle(1);
    drive(0, '0, 1, 32'd7); idle(1);
    drive(0, '0, 1, 32'd9); idle(6);
    check("gap_err",      32'(err_count), 32'd1);
    check("gap_err_lane", 32'(err_lane),  32'd2);
    check("gap_match",    match_count,    32'd3);

    // Flush resync on lane 1 with two entries queued.
    do_reset("rst_fl");
    drive(1, 32'd0, 0, '0);
    drive(1, 32'd2, 0, '0);
    drive(1, 32'd4, 0, '0);
    check("flush_queued", 32'(sb_size(0)), 32'd2);
    flush_1 = 1'b1;
    drive(1, 32'd6, 0, '0);
    flush_1 = 1'b0;
    drive(1, 32'd100, 0, '0);
    drive(1, 32'd102, 0, '0);
    idle(6);
    check("flush_match", match_count,    32'd3);
    check("flush_err",   32'(err_count), 32'd0);

    // Overflow: fill lane 1, push at full on a tick (accepted), then off-tick (dropped).
    do_reset("rst_ovf");
    seq = 0;
    for (int i = 0; i < 40; i++) begin
      if (sb_size(0) == DEPTH && m_drain == PERIOD - 1) break;
      drive(1, 32'(2 * seq), 0, '0);
      seq++;
    end
    check("ovf_full_stall", 32'(stall_1), 32'd1);
    drive(1, 32'(2 * seq), 0, '0);
    seq++;
    check("ovf_tick_push", 32'(overflow), 32'd0);
    drive(1, 32'd999, 0, '0);
    check("ovf_drop_push", 32'(overflow), 32'd1);
    idle(24);
    check("ovf_match", match_count,    32'(seq));
    check("ovf_err",   32'(err_count), 32'd0);

    // Reset mid-stream with errors recorded and both FIFOs partly full.
    do_reset("rst_mid0");
    drive(1, 32'd0,  0, '0); idle(1);
    drive(1, 32'd5,  0, '0); idle(1);
    drive(1, 32'd10, 0, '0); idle(1);
    drive(1, 32'd15, 0, '0); idle(4);
    check("mid_err3",     32'(err_count), 32'd3);
    check("mid_err_lane", 32'(err_lane),  32'd1);
    for (int i = 0; i < 8; i++) drive(1, 32'(200 + 2 * i), 1, 32'(301 + 2 * i));
    do_reset("rst_mid");
    drive(1, 32'd50, 1, 32'd77);
    idle(4);
    check("post_rst_match", match_count,    32'd2);
    check("post_rst_err",   32'(err_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
